// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: FSM state
// encoding, the supported opcodes and the alu_op / pc_src select encodings.
// Optional feature macro used by the design: MEM_WAIT_EN.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_ALU_R     = 7'b0110011;
    localparam logic [6:0] OP_ALU_I     = 7'b0010011;
    localparam logic [6:0] OP_BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] OP_JUMP      = 7'b1101111;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_ALU_R, OP_ALU_I, OP_BRANCH_EQ,
            OP_JUMP, OP_LOAD, OP_STORE: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Per-access memory wait counter. Counts consecutive cycles in which an
// access is outstanding without mem_ready, clears whenever no wait is in
// progress, and flags the cycle that is the TIMEOUT-th such wait cycle.
// Only instantiated when MEM_WAIT_EN is defined.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic arst_n,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic          waiting;

    assign waiting = active && !mem_ready;
    assign expired = waiting && (cnt_q == LAST);

    // Count wait cycles of the current access; restart for every new access.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else if (!waiting || expired) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
// Strobes are decoded from the current state and the opcode latched in
// DECODE. Define MEM_WAIT_EN to make FETCH/MEM wait on mem_ready with a
// MEM_TIMEOUT-cycle watchdog; without it every access takes one cycle.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       enable,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_2_reg,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state
);

    // Memory handshake: mem_read/mem_write is held high for the whole access
    // and the access completes on a cycle where mem_ready is sampled high;
    // the request stays stable until then and drops the cycle after.

    state_t     state_q, state_d;
    logic [6:0] opcode_q;
    logic       illegal_q;
    logic       illegal_set;
    logic       retire_now;
    logic       mem_done;
    logic       mem_expired;

`ifdef MEM_WAIT_EN
    logic mem_phase;
    logic timeout_q;

    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_done  = mem_ready;

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .arst_n    (arst_n),
        .active    (mem_phase),
        .mem_ready (mem_ready),
        .expired   (mem_expired)
    );

    // Sticky timeout flag, set when an access exhausts its wait budget.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            timeout_q <= 1'b0;
        end else if (mem_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    localparam int unused_mem_timeout = MEM_TIMEOUT;
    logic unused_mem_ready;

    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
    assign mem_expired      = 1'b0;
    assign timeout          = 1'b0;
`endif

    assign state   = state_q;
    assign illegal = illegal_q;

    // State register, opcode latch (in DECODE) and sticky illegal flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode; every instruction ends in a retire step.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_2_reg   = 1'b0;
        alu_src     = 1'b0;
        alu_op      = ALU_OP_ADD;
        pc_src      = PC_SRC_SEQ;
        retire      = 1'b0;
        retire_now  = 1'b0;
        illegal_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_SEQ;
                    state_d  = S_DECODE;
                end else if (mem_expired) begin
                    state_d = S_HALT;
                end
            end

            S_DECODE: begin
                if (is_legal_op(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_set = 1'b1;
                    state_d     = S_HALT;
                end
            end

            S_EXEC: begin
                case (opcode_q)
                    OP_ALU_R: begin
                        alu_op  = ALU_OP_RTYPE;
                        alu_src = 1'b0;
                        state_d = S_WB;
                    end
                    OP_ALU_I: begin
                        alu_op  = ALU_OP_RTYPE;
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end
                    OP_BRANCH_EQ: begin
                        alu_op     = ALU_OP_SUB;
                        alu_src    = 1'b0;
                        pc_src     = PC_SRC_BRANCH;
                        pc_write   = zero;
                        retire_now = 1'b1;
                    end
                    OP_JUMP: begin
                        alu_op     = ALU_OP_RTYPE;
                        alu_src    = 1'b0;
                        reg_write  = 1'b1;
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_JUMP;
                        retire_now = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op  = ALU_OP_ADD;
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    default: begin
                        // Not reachable: DECODE filters illegal opcodes.
                        state_d = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                if (opcode_q == OP_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (mem_done) begin
                    if (opcode_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        retire_now = 1'b1;
                    end
                end else if (mem_expired) begin
                    state_d = S_HALT;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_2_reg  = (opcode_q == OP_LOAD);
                retire_now = 1'b1;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Enable is only consulted here, so dropping it never aborts an
        // instruction in flight.
        if (retire_now) begin
            retire  = 1'b1;
            state_d = enable ? S_FETCH : S_IDLE;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: reset checks, a table of instruction
// vectors run back to back through a scoreboard, and hand-written
// sequences for enable drop, mid-access reset, illegal opcode and (with
// MEM_WAIT_EN) memory wait/timeout behaviour.
`timescale 1ns/1ps
module tb_multicycle_control;
    import multicycle_control_pkg::*;

`ifdef MEM_WAIT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 15;
`endif
    localparam int OW = 19;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       arst_n;
    logic       enable;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, mem_2_reg, alu_src;
    logic [1:0] alu_op, pc_src;
    logic       retire, illegal, timeout;
    logic [2:0] state;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .enable    (enable),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_2_reg (mem_2_reg),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .retire    (retire),
        .illegal   (illegal),
        .timeout   (timeout),
        .state     (state)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [OW-1:0] exp_q[$];

    typedef struct {
        logic [6:0]    op;
        logic          z;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] strobes();
        return {pc_write, ir_write, reg_write, mem_read, mem_write, mem_2_reg,
                alu_src, alu_op, pc_src, retire};
    endfunction

    // Packed per-instruction observation:
    // latency, EXEC alu_op/alu_src/pc_write/pc_src(when writing)/reg_write,
    // MEM read/write seen, WB load writeback, clean fetch, reg_write and
    // pc_write pulse counts over the instruction.
    function automatic logic [OW-1:0] mk(input int lat, input logic [1:0] aop,
                                         input logic asrc, input logic pcw,
                                         input logic [1:0] psrc, input logic rw,
                                         input logic mrd, input logic mwr,
                                         input logic m2r, input logic fok,
                                         input int rwc, input int pwc);
        return {4'(lat), aop, asrc, pcw, psrc, rw, mrd, mwr, m2r, fok, 2'(rwc), 2'(pwc)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
        int n;
        n = 0;
        while (state !== s && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(state), 32'(s));
    endtask

    task automatic run_instr(input vec_t v, input int idx);
        logic [3:0]    lat;
        logic [1:0]    ex_aop, ex_psrc, rw_c, pw_c;
        logic          ex_asrc, ex_pcw, ex_rw, m_rd, m_wr, wb_m2r, f_ok;
        bit            started, done;
        int            guard;
        logic [OW-1:0] exp_w;
        lat = '0; ex_aop = '0; ex_psrc = '0; rw_c = '0; pw_c = '0;
        ex_asrc = 0; ex_pcw = 0; ex_rw = 0; m_rd = 0; m_wr = 0; wb_m2r = 0; f_ok = 0;
        started = 0; done = 0; guard = 0;
        exp_q.push_back(v.exp);
        opcode = v.op;
        zero   = v.z;
        while (!done && guard < 40) begin
            @(negedge clk);
            guard++;
            // Scramble the opcode input once it has been decoded.
            if (state == S_EXEC || state == S_MEM || state == S_WB) opcode = 7'b1111111;
`ifdef MEM_WAIT_EN
            mem_ready = 1'b1;
`else
            mem_ready = 1'($urandom_range(0, 1));
`endif
            #1;
            if (state == S_FETCH) started = 1;
            if (started) begin
                lat++;
                if (reg_write) rw_c++;
                if (pc_write) pw_c++;
                case (state)
                    S_FETCH: if (ir_write && pc_write && mem_read && pc_src == 2'b00) f_ok = 1;
                    S_EXEC: begin
                        ex_aop  = alu_op;
                        ex_asrc = alu_src;
                        ex_pcw  = pc_write;
                        ex_psrc = pc_write ? pc_src : 2'b00;
                        ex_rw   = reg_write;
                    end
                    S_MEM: begin
                        m_rd = m_rd | mem_read;
                        m_wr = m_wr | mem_write;
                    end
                    S_WB: wb_m2r = reg_write & mem_2_reg;
                    default: ;
                endcase
                if (retire) done = 1;
            end
        end
        check($sformatf("vec%0d_retired", idx), 32'(done), 32'd1);
        exp_w = exp_q.pop_front();
        check($sformatf("vec%0d_op%07b_z%0b", idx, v.op, v.z),
              32'({lat, ex_aop, ex_asrc, ex_pcw, ex_psrc, ex_rw, m_rd, m_wr, wb_m2r, f_ok, rw_c, pw_c}),
              32'(exp_w));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [14:0] seq;
        logic [4:0]  rw_mask;
        int          ret_at;
        bit          ok;
`ifdef MEM_WAIT_EN
        int          f_seen, m_seen, rd_cnt, ir_cnt, f_cnt;
        bit          wb_ok, done;
`endif

        //             op           z     lat aop   src pcw psrc  rw  mrd mwr m2r fok rwc pwc
        vecs[0] = '{7'b0110011, 1'b0, mk(4, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1)};
        vecs[1] = '{7'b0010011, 1'b0, mk(4, 2'b10, 1, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1)};
        vecs[2] = '{7'b1100011, 1'b1, mk(3, 2'b01, 0, 1, 2'b01, 0, 0, 0, 0, 1, 0, 2)};
        vecs[3] = '{7'b1100011, 1'b0, mk(3, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1)};
        vecs[4] = '{7'b1101111, 1'b0, mk(3, 2'b10, 0, 1, 2'b10, 1, 0, 0, 0, 1, 1, 2)};
        vecs[5] = '{7'b0000011, 1'b0, mk(5, 2'b00, 1, 0, 2'b00, 0, 1, 0, 1, 1, 1, 1)};
        vecs[6] = '{7'b0100011, 1'b1, mk(4, 2'b00, 1, 0, 2'b00, 0, 0, 1, 0, 1, 0, 1)};
        vecs[7] = '{7'b1101111, 1'b1, mk(3, 2'b10, 0, 1, 2'b10, 1, 0, 0, 0, 1, 1, 2)};
        vecs[8] = '{7'b0000011, 1'b1, mk(5, 2'b00, 1, 0, 2'b00, 0, 1, 0, 1, 1, 1, 1)};
        vecs[9] = '{7'b0110011, 1'b1, mk(4, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1)};

        // Reset: everything idle regardless of inputs.
        arst_n = 1'b0; enable = 1'b1; opcode = 7'b0110011; zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(state), 32'(S_IDLE));
        check("reset_outputs", 32'({strobes(), illegal, timeout}), 32'd0);

        // Release with enable low: must stay in IDLE.
        @(negedge clk);
        enable = 1'b0;
        arst_n = 1'b1;
        ok = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (state !== S_IDLE || strobes() !== 12'd0) ok = 0;
        end
        check("idle_hold_enable_low", 32'(ok), 32'd1);

        // R-type from IDLE: IDLE,FETCH,DECODE,EXEC,WB, retire on cycle 5.
        enable = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
        seq = {12'd0, S_IDLE};
        rw_mask = '0;
        ret_at = 0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            #1;
            seq = {seq[11:0], state};
            if (reg_write) rw_mask[c-1] = 1'b1;
            if (retire && ret_at == 0) ret_at = c;
        end
        enable = 1'b0;
        check("rtype_state_seq", 32'(seq), 32'({S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB}));
        check("rtype_reg_write_wb_only", 32'(rw_mask), 32'(5'b10000));
        check("rtype_retire_cycle", 32'(ret_at), 32'd5);
        @(negedge clk);
        #1;
        check("retire_to_idle", 32'(state), 32'(S_IDLE));

        // Table of instructions, back to back with enable held high.
        enable = 1'b1;
        for (int i = 0; i < 10; i++) run_instr(vecs[i], i);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Enable dropped during EXEC of a store: store still completes.
        opcode = 7'b0100011; zero = 1'b0; mem_ready = 1'b1;
        wait_state(S_EXEC, 10, "store_reach_exec");
        enable = 1'b0;
        @(negedge clk);
        #1;
        check("store_mem_retire", 32'({state, mem_write, mem_read, retire}), 32'({S_MEM, 3'b101}));
        @(negedge clk);
        #1;
        check("store_then_idle", 32'({state, retire}), 32'({S_IDLE, 1'b0}));

        // Asynchronous reset in the middle of a load's memory access.
        enable = 1'b1; opcode = 7'b0000011;
        wait_state(S_MEM, 10, "load_reach_mem");
        mem_ready = 1'b0;
        arst_n = 1'b0;
        #1;
        check("async_reset_mid_mem", 32'({state, strobes(), illegal, timeout}), 32'({S_IDLE, 14'd0}));
        @(negedge clk);
        enable = 1'b0;
        arst_n = 1'b1;
        mem_ready = 1'b1;

        // Illegal opcode: HALT is absorbing, strobes stay low.
        @(negedge clk);
        enable = 1'b1; opcode = 7'b1111111;
        wait_state(S_HALT, 10, "illegal_to_halt");
        check("illegal_flag", 32'({illegal, timeout}), 32'b10);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            enable    = 1'($urandom_range(0, 1));
            opcode    = 7'($urandom_range(0, 127));
            zero      = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (state !== S_HALT || strobes() !== 12'd0 || illegal !== 1'b1) ok = 0;
        end
        check("halt_absorbing", 32'(ok), 32'd1);
        @(negedge clk);
        enable = 1'b0; mem_ready = 1'b1;
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
        #1;
        check("halt_reset_pulse", 32'({state, illegal}), 32'({S_IDLE, 1'b0}));

`ifdef MEM_WAIT_EN
        // Load with 2 fetch waits and 3 memory waits.
        @(negedge clk);
        opcode = 7'b0000011; zero = 1'b0; enable = 1'b1; mem_ready = 1'b0;
        f_seen = 0; m_seen = 0; rd_cnt = 0; ir_cnt = 0; wb_ok = 0; done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (state == S_FETCH) begin
                f_seen++;
                mem_ready = (f_seen > 2);
            end else if (state == S_MEM) begin
                m_seen++;
                mem_ready = (m_seen > 3);
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (ir_write) ir_cnt++;
            if (state == S_MEM && mem_read) rd_cnt++;
            if (state == S_WB && reg_write && mem_2_reg) wb_ok = 1;
            if (retire) begin
                done = 1;
                enable = 1'b0;
            end
        end
        check("wait_load_retired", 32'(done), 32'd1);
        check("wait_fetch_cycles", 32'(f_seen), 32'd3);
        check("wait_ir_write_once", 32'(ir_cnt), 32'd1);
        check("wait_mem_read_held", 32'(rd_cnt), 32'd4);
        check("wait_load_wb", 32'(wb_ok), 32'd1);
        check("wait_no_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        #1;
        check("wait_load_to_idle", 32'(state), 32'(S_IDLE));

        // Fetch never acknowledged: timeout after TB_TIMEOUT wait cycles.
        opcode = 7'b0110011; mem_ready = 1'b0; enable = 1'b1;
        f_cnt = 0;
        for (int i = 0; i < 20 && state !== S_HALT; i++) begin
            @(negedge clk);
            #1;
            if (state == S_FETCH) f_cnt++;
        end
        check("timeout_fetch_cycles", 32'(f_cnt), 32'd4);
        check("timeout_halt", 32'({state, timeout, illegal}), 32'({S_HALT, 2'b10}));
        check("timeout_halt_strobes", 32'(strobes()), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        arst_n = 1'b0;
        #1;
        check("timeout_cleared_by_reset", 32'({state, timeout}), 32'({S_IDLE, 1'b0}));
        @(negedge clk);
        arst_n = 1'b1;
`else
        // Without wait support, timeout must never rise even with ready low.
        @(negedge clk);
        opcode = 7'b0100011; mem_ready = 1'b0; enable = 1'b1;
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (timeout !== 1'b0 || state == S_HALT) ok = 0;
        end
        check("no_wait_ready_ignored", 32'(ok), 32'd1);
        enable = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles per memory access (used only with MEM_WAIT_EN).
REQ-002 SHALL have port clk  in  1  single clock, rising edge.
REQ-003 SHALL have port arst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  in  1  run request; sampled in IDLE and at each retire.
REQ-005 SHALL have port opcode  in  7  RISC-V opcode[6:0] from the instruction register.
REQ-006 SHALL have port zero  in  1  ALU zero flag, for BEQ resolution.
REQ-007 SHALL have port mem_ready  in  1  memory access complete.
REQ-008 SHALL have ports pc_write, ir_write, reg_write, mem_read, mem_write, mem_2_reg, alu_src  out  1 each  datapath strobes/selects.
REQ-009 SHALL have port alu_op  out  2  00 add, 01 sub, 10 R-type decode.
REQ-010 SHALL have port pc_src  out  2  00 PC+4, 01 branch target, 10 jump target.
REQ-011 SHALL have ports retire, illegal, timeout  out  1 each  one-cycle retire pulse, sticky illegal-opcode flag, sticky memory-timeout flag.
REQ-012 SHALL have port state  out  3  current FSM state, for debug.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT, with Moore outputs decoded from state and latched opcode.
REQ-014 IDLE SHALL go to FETCH when enable=1; all strobes SHALL be 0 in IDLE.
REQ-015 FETCH SHALL assert mem_read; on completion it SHALL pulse ir_write and pc_write (pc_src=00) in the same cycle and go to DECODE.
REQ-016 DECODE SHALL latch opcode into an internal register; ALU_R (0110011), ALU_I (0010011), BRANCH_EQ (1100011), JUMP (1101111), LOAD (0000011) and STORE (0100011) SHALL go to EXEC, and any other value SHALL go to HALT with illegal set.
REQ-017 EXEC SHALL drive alu_op/alu_src per class:
  - R: 10/0
  - I: 10/1
  - BEQ: 01/0
  - LOAD/STORE: 00/1
  - JUMP: 10/0
REQ-018 EXEC routing SHALL be: R/I -> WB; LOAD/STORE -> MEM.
REQ-019 EXEC BEQ SHALL pulse pc_write with pc_src=01 only if zero=1, then retire.
REQ-020 EXEC JUMP SHALL pulse reg_write and pc_write (pc_src=10), then retire.
REQ-021 MEM SHALL hold mem_read (LOAD) or mem_write (STORE) until completion; LOAD SHALL go to WB and STORE SHALL retire.
REQ-022 WB SHALL pulse reg_write for one cycle, with mem_2_reg=1 only for LOAD, then retire.
REQ-023 Retire SHALL pulse retire for one cycle; the next state SHALL be FETCH if enable=1, else IDLE.
REQ-024 HALT SHALL be absorbing until reset; all strobes SHALL be 0 in HALT.
REQ-025 Deasserting enable mid-instruction SHALL NOT abort it; it takes effect only at retire.
REQ-026 Instruction latency SHALL be: R/I = 4 cycles, BEQ/JUMP = 3 cycles, STORE = 4 cycles, LOAD = 5 cycles (zero-wait memory).

Reset
REQ-027 arst_n=0 SHALL immediately force state=IDLE, all outputs 0, illegal=0, timeout=0, latched opcode=0 and wait counter=0, including mid-access.
REQ-028 After reset release, the first FETCH SHALL occur no earlier than the cycle after enable is sampled 1.

Configuration
REQ-029 With macro MEM_WAIT_EN defined, FETCH and MEM SHALL complete only on a cycle with mem_ready=1 and SHALL count wait cycles.
REQ-030 With MEM_WAIT_EN defined, reaching MEM_TIMEOUT wait cycles without mem_ready SHALL set timeout and go to HALT.
REQ-031 Without MEM_WAIT_EN, FETCH and MEM SHALL complete in exactly one cycle, mem_ready SHALL be ignored, timeout SHALL be tied to 0, and no counter SHALL be built.

Structure
REQ-032 Opcode constants, alu_op encodings, pc_src encodings and the state enum SHALL live in a shared package, reused by control_unit.
REQ-033 The wait counter SHALL be an optional sub-module mem_wait_timer, instantiated only under MEM_WAIT_EN; all other logic SHALL be flat.

Verification
REQ-034 Reset, enable=1, opcode=0110011, mem_ready=1 -> states IDLE,FETCH,DECODE,EXEC,WB; reg_write=1 in WB only; retire on cycle 5.
REQ-035 opcode=1100011: with zero=1 -> pc_write=1 and pc_src=01 in EXEC; with zero=0 -> pc_write=0 in EXEC; retire in both cases.
REQ-036 opcode=0000011 with mem_ready low for 3 cycles in MEM (MEM_WAIT_EN) -> mem_read held 4 cycles, then WB with mem_2_reg=1 and reg_write=1.
REQ-037 opcode=1111111 -> HALT, illegal=1, all strobes 0 for 20 cycles; arst_n pulse -> IDLE, illegal=0.
REQ-038 MEM_WAIT_EN with MEM_TIMEOUT=4 and mem_ready=0 in FETCH -> timeout=1 and HALT after 4 wait cycles.
REQ-039 enable dropped during the EXEC of opcode=0100011 -> store completes, retire pulses, next state IDLE.
